muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multi-cycle sequencer for RV32M multiply/divide/remainder.
- Instantiates one `alu` and drives it with the `ADD`/`SUB` control codes from macro.vh, one add/subtract per iteration.
- Sits beside the main ALU in the EX stage; the pipeline stalls on `req_ready`/`busy` until `resp_valid`.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept (high only in IDLE)
- req_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a  input  32  rs1 operand
- req_b  input  32  rs2 operand
- flush  input  1  abort in-flight operation (pipeline kill)
- busy  output  1  operation in flight (state != IDLE)
- resp_valid  output  1  one-cycle pulse, result valid
- resp_data  output  32  result, held until next accept

Behaviour:
- Interface: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, busy=0, resp_valid=0, resp_data=0, counter=0, internal regs=0.
- Accept: on an edge where req_valid && req_ready. Latch op/a/b; go to PREP.
- States: IDLE, PREP, ITER, FIX, DONE.
- PREP (1 cycle):
  - Determine operand signedness per op: MULH both signed; MULHSU a signed, b unsigned; DIV/REM both signed.
  - Record result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Replace negative signed operands with their magnitude (two's-complement negate via the ALU SUB from 0).
  - Clear the 64-bit accumulator; counter=0; go to ITER.
- PREP special cases (DIV/DIVU/REM/REMU only; skip ITER/FIX, go to DONE):
  - b==0: quotient=0xFFFFFFFF, remainder=a.
  - Signed overflow, DIV/REM with a=0x80000000 and b=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- ITER, XLEN cycles, one bit per cycle, counter increments each cycle:
  - Multiply (shift-add): if multiplier LSB=1, acc_hi = acc_hi + multiplicand via ALU ADD, carry kept as bit 64. Then shift {carry,acc_hi,multiplier} right by 1.
  - Divide (restoring): shift {rem,quot} left 1. Trial = rem - divisor via ALU SUB. If there is no borrow, rem=trial and quot LSB=1; else quot LSB=0.
  - Leave ITER when counter==XLEN-1 at the clock edge.
- FIX (1 cycle):
  - If the recorded sign is negative, negate the 64-bit product, or the quotient/remainder as applicable.
  - Select the result: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
- DONE (1 cycle): resp_valid=1, resp_data=result; next state IDLE.
- Latency, accept edge = T:
  - Normal path: resp_valid high in cycle T+35.
  - Divide special case: resp_valid high in cycle T+2.
- req_ready=1 only in IDLE. A request arriving in the same cycle as resp_valid is not accepted; it is accepted one cycle later.
- resp_data holds its last value after DONE until the next DONE.
- flush:
  - In any non-IDLE state: go to IDLE next edge, no resp_valid, resp_data unchanged.
  - Flush takes priority over DONE: if asserted in DONE, resp_valid is still 0 that cycle.
  - In IDLE, flush blocks acceptance in that cycle.
- rst mid-operation: all state to reset values next edge; no response.
- Arithmetic: 32-bit wrap-around modulo 2^32 for the MUL low half; no exceptions or flags raised.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined, multiply ops:
  - In ITER, if the remaining unshifted multiplier bits are all zero, shift the accumulator right by the remaining count in one cycle and go to FIX.
  - Minimum multiply latency (b==0) drops to T+4.
  - Divide timing is unchanged.
- Undefined: fixed XLEN-cycle ITER for every op; latency always T+35 (T+2 for divide special cases).

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> resp_data=0xFFFFFFEB; resp_valid exactly at T+35 with macro off.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14; REMU -> 2.
- DIV b=0, a=5 -> 0xFFFFFFFF at T+2; REM b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0.
- Assert flush at T+10 of a DIV -> no resp_valid, req_ready=1 at T+11, resp_data unchanged; new MUL 3*4 accepted -> 12.
- Back-to-back: req_valid held high through DONE -> second accept at T+36, not T+35. With MULDIV_EARLY_OUT_EN defined, MUL a=5, b=1 -> 5 at T+4.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide/remainder sequencer.
//
// One adder/subtractor (module alu) is shared by every step. PREP uses it to
// form the magnitude of a. ITER uses it for one shift-add or one restoring
// subtract per cycle. The magnitude of b and the final sign fix-up in FIX use
// small two's-complement helper functions.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_op              RV32M funct3 (000 MUL .. 111 REMU)
//   req_a, req_b        rs1 / rs2 operands
//   flush               abort any in-flight operation; blocks accept while idle
//   busy                operation in flight
//   resp_valid          one-cycle result strobe
//   resp_data           result, held until the next result
//
// Optional build macro MULDIV_EARLY_OUT_EN: a multiply leaves ITER as soon as
// its remaining multiplier bits are all zero. Divide timing is unaffected.

module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);

  localparam logic [3:0]       ALU_ADD  = 4'd0;
  localparam logic [3:0]       ALU_SUB  = 4'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
    neg32 = ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] x);
    neg64 = ~x + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t              state_r;
  logic [2:0]          op_r;
  logic [XLEN-1:0]     a_r;
  logic [XLEN-1:0]     b_r;
  logic [XLEN-1:0]     opnd_r;     // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0]   acc_r;      // {acc_hi, multiplier} or {rem, quot}
  logic [CNT_W-1:0]    cnt_r;
  logic                qneg_r;     // product / quotient is negative
  logic                rneg_r;     // remainder is negative
  logic [XLEN-1:0]     result_r;   // result produced by FIX or a special case
  logic [XLEN-1:0]     data_r;     // last delivered result

  logic [XLEN-1:0]     alu_a_s;
  logic [XLEN-1:0]     alu_b_s;
  logic [3:0]          alu_ctrl_s;
  logic [XLEN-1:0]     alu_y_s;
  logic                alu_cout_s;

  logic                a_signed_s;
  logic                b_signed_s;
  logic                sa_s;
  logic                sb_s;
  logic [XLEN-1:0]     a_mag_s;
  logic [XLEN-1:0]     b_mag_s;
  logic                special_s;
  logic [XLEN-1:0]     special_res_s;

  logic [XLEN:0]       sum_s;
  logic [2*XLEN-1:0]   mul_next_s;
  logic                div_ok_s;
  logic [2*XLEN-1:0]   div_next_s;

  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quot_s;
  logic [XLEN-1:0]     rem_s;
  logic [XLEN-1:0]     fix_res_s;

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0]     rem_bits_s;
  logic                early_s;
  logic [2*XLEN-1:0]   early_acc_s;
`endif

  alu #(.W(XLEN)) u_alu (
    .a    (alu_a_s),
    .b    (alu_b_s),
    .ctrl (alu_ctrl_s),
    .y    (alu_y_s),
    .cout (alu_cout_s)
  );

  // Steer the shared adder: negate a in PREP, add/subtract in ITER.
  always_comb begin
    alu_a_s    = {XLEN{1'b0}};
    alu_b_s    = {XLEN{1'b0}};
    alu_ctrl_s = ALU_ADD;
    case (state_r)
      S_PREP: begin
        alu_a_s    = {XLEN{1'b0}};
        alu_b_s    = a_r;
        alu_ctrl_s = ALU_SUB;
      end
      S_ITER: begin
        if (op_r[2]) begin
          // remainder after the left shift, minus divisor
          alu_a_s    = acc_r[2*XLEN-2:XLEN-1];
          alu_b_s    = opnd_r;
          alu_ctrl_s = ALU_SUB;
        end else begin
          alu_a_s    = acc_r[2*XLEN-1:XLEN];
          alu_b_s    = opnd_r;
          alu_ctrl_s = ALU_ADD;
        end
      end
      default: begin
        alu_a_s    = {XLEN{1'b0}};
        alu_b_s    = {XLEN{1'b0}};
        alu_ctrl_s = ALU_ADD;
      end
    endcase
  end

  // Operand signedness, magnitudes and divide special cases for PREP.
  always_comb begin
    a_signed_s = (op_r == 3'b001) || (op_r == 3'b010) || (op_r == 3'b100) || (op_r == 3'b110);
    b_signed_s = (op_r == 3'b001) || (op_r == 3'b100) || (op_r == 3'b110);
    sa_s       = a_signed_s & a_r[XLEN-1];
    sb_s       = b_signed_s & b_r[XLEN-1];
    if (sa_s) begin
      a_mag_s = alu_y_s;
    end else begin
      a_mag_s = a_r;
    end
    if (sb_s) begin
      b_mag_s = neg32(b_r);
    end else begin
      b_mag_s = b_r;
    end
    special_s     = 1'b0;
    special_res_s = {XLEN{1'b0}};
    if (op_r[2] && (b_r == {XLEN{1'b0}})) begin
      special_s = 1'b1;
      if (op_r[1]) begin
        special_res_s = a_r;
      end else begin
        special_res_s = {XLEN{1'b1}};
      end
    end else if (op_r[2] && !op_r[0] && (a_r == 32'h8000_0000) && (b_r == 32'hFFFF_FFFF)) begin
      special_s = 1'b1;
      if (op_r[1]) begin
        special_res_s = {XLEN{1'b0}};
      end else begin
        special_res_s = 32'h8000_0000;
      end
    end else begin
      special_s     = 1'b0;
      special_res_s = {XLEN{1'b0}};
    end
  end

  // One ITER step for multiply (shift-add) and divide (restoring).
  always_comb begin
    if (acc_r[0]) begin
      sum_s = {alu_cout_s, alu_y_s};
    end else begin
      sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
    end
    mul_next_s = {sum_s, acc_r[XLEN-1:1]};
    // a carry out of the shifted remainder's top bit also means no borrow
    div_ok_s   = acc_r[2*XLEN-1] | alu_cout_s;
    if (div_ok_s) begin
      div_next_s = {alu_y_s, acc_r[XLEN-2:0], 1'b1};
    end else begin
      div_next_s = {acc_r[2*XLEN-2:0], 1'b0};
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Multiplier bits not yet consumed after this step; if none remain, finish
  // all outstanding right shifts at once.
  always_comb begin
    rem_bits_s  = (acc_r[XLEN-1:0] >> 1'b1) & ({XLEN{1'b1}} >> (int'(cnt_r) + 1));
    early_s     = (rem_bits_s == {XLEN{1'b0}});
    early_acc_s = mul_next_s >> (XLEN - 1 - int'(cnt_r));
  end
`endif

  // Sign fix-up and result selection for FIX.
  always_comb begin
    if (qneg_r) begin
      prod_s = neg64(acc_r);
      quot_s = neg32(acc_r[XLEN-1:0]);
    end else begin
      prod_s = acc_r;
      quot_s = acc_r[XLEN-1:0];
    end
    if (rneg_r) begin
      rem_s = neg32(acc_r[2*XLEN-1:XLEN]);
    end else begin
      rem_s = acc_r[2*XLEN-1:XLEN];
    end
    case (op_r)
      3'b000:                 fix_res_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res_s = quot_s;
      default:                fix_res_s = rem_s;
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      op_r     <= 3'd0;
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      opnd_r   <= {XLEN{1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      qneg_r   <= 1'b0;
      rneg_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
      data_r   <= {XLEN{1'b0}};
    end else if (flush && (state_r != S_IDLE)) begin
      state_r <= S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid && !flush) begin
            op_r    <= req_op;
            a_r     <= req_a;
            b_r     <= req_b;
            state_r <= S_PREP;
          end
        end
        S_PREP: begin
          qneg_r <= sa_s ^ sb_s;
          rneg_r <= sa_s;
          cnt_r  <= {CNT_W{1'b0}};
          if (special_s) begin
            result_r <= special_res_s;
            state_r  <= S_DONE;
          end else if (op_r[2]) begin
            opnd_r  <= b_mag_s;
            acc_r   <= {{XLEN{1'b0}}, a_mag_s};
            state_r <= S_ITER;
          end else begin
            opnd_r  <= a_mag_s;
            acc_r   <= {{XLEN{1'b0}}, b_mag_s};
            state_r <= S_ITER;
          end
        end
        S_ITER: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (op_r[2]) begin
            acc_r <= div_next_s;
          end else begin
`ifdef MULDIV_EARLY_OUT_EN
            if (early_s) begin
              acc_r <= early_acc_s;
            end else begin
              acc_r <= mul_next_s;
            end
`else
            acc_r <= mul_next_s;
`endif
          end
          if (cnt_r == CNT_LAST) begin
            state_r <= S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
          end else if (!op_r[2] && early_s) begin
            state_r <= S_FIX;
`endif
          end else begin
            state_r <= S_ITER;
          end
        end
        S_FIX: begin
          result_r <= fix_res_s;
          state_r  <= S_DONE;
        end
        S_DONE: begin
          data_r  <= result_r;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_r == S_IDLE);
  assign busy       = (state_r != S_IDLE);
  // flush in DONE suppresses the strobe in that same cycle
  assign resp_valid = (state_r == S_DONE) && !flush;
  assign resp_data  = resp_valid ? result_r : data_r;

endmodule

// alu: W-bit adder/subtractor. ctrl 0 = ADD, 1 = SUB (a + ~b + 1).
// cout is the carry out; for SUB, cout=1 means no borrow.
module alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [W-1:0] y,
  output logic         cout
);

  localparam logic [3:0] ALU_SUB = 4'd1;

  logic         sub_s;
  logic [W-1:0] b_eff_s;
  logic [W:0]   sum_s;

  // Add or subtract with carry out.
  always_comb begin
    sub_s = (ctrl == ALU_SUB);
    if (sub_s) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
    sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{W{1'b0}}, sub_s};
  end

  assign y    = sum_s[W-1:0];
  assign cout = sum_s[W];

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a transaction-level model (expected
// result and latency per request) drives a per-cycle compare of ready, busy,
// resp_valid and resp_data; directed vectors pin the model with literals.

module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // transaction model state
  bit          pending    = 1'b0;
  int          done_cyc   = 0;
  logic [31:0] exp_data   = 32'd0;
  logic [31:0] model_data = 32'd0;
  bit          check_en   = 1'b0;
  bit          ev;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_M1 = 4;   // multiplier 1 or 0
  localparam int LAT_M4 = 6;   // multiplier 4
`else
  localparam int LAT_M1 = 35;
  localparam int LAT_M4 = 35;
`endif

  muldiv_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb, p;
    logic signed [31:0] sa, sb;
    logic [63:0] up;
    sa = a;
    sb = b;
    case (op)
      3'b000: ref_result = a * b;
      3'b001: begin pa = sa; pb = sb; p = pa * pb; ref_result = p[63:32]; end
      3'b010: begin pa = sa; pb = {32'd0, b}; p = pa * pb; ref_result = p[63:32]; end
      3'b011: begin up = {32'd0, a} * {32'd0, b}; ref_result = up[63:32]; end
      3'b100: begin
        if (b == 32'd0) ref_result = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h8000_0000;
        else ref_result = sa / sb;
      end
      3'b101: ref_result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) ref_result = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'd0;
        else ref_result = sa % sb;
      end
      default: ref_result = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    int l;
    if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[2]) begin
      m = (op == 3'b001 && b[31]) ? (~b + 32'd1) : b;
      l = 4;
      for (int i = 0; i < 32; i++) if (m[i]) l = i + 4;
      return l;
    end
`endif
    l = 35;
    return l;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: accept/flush/completion bookkeeping at each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      pending    = 1'b0;
      model_data = 32'd0;
    end else if (pending) begin
      if (flush) pending = 1'b0;
      else if (cyc == done_cyc + 1) begin
        pending    = 1'b0;
        model_data = exp_data;
      end
    end else if (req_valid && !flush) begin
      pending  = 1'b1;
      exp_data = ref_result(req_op, req_a, req_b);
      done_cyc = cyc + ref_lat(req_op, req_a, req_b) - 1;
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (check_en) begin
      ev = pending && (cyc == done_cyc) && !flush;
      chk("cyc_resp_valid", {31'd0, resp_valid}, {31'd0, ev});
      chk("cyc_req_ready", {31'd0, req_ready}, {31'd0, !pending});
      chk("cyc_busy", {31'd0, busy}, {31'd0, pending});
      chk("cyc_resp_data", resp_data, ev ? exp_data : model_data);
    end
  end

  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input int exp_lat, input bit pin, input bit keep,
                       output int t_acc);
    int w;
    if (pin) begin
      chk({nm, "_model_data"}, ref_result(op, a, b), exp_d);
      chk({nm, "_model_lat"}, ref_lat(op, a, b), exp_lat);
    end
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!req_ready && w < 100);
    chk({nm, "_ready_seen"}, {31'd0, req_ready}, 32'd1);
    t_acc = -1;
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    t_acc = cyc;
    if (!keep) req_valid = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!resp_valid && w < 60);
    chk({nm, "_resp_seen"}, {31'd0, resp_valid}, 32'd1);
    if (!resp_valid) return;
    chk({nm, "_latency"}, cyc - t_acc + 1, exp_lat);
    chk({nm, "_data"}, resp_data, exp_d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    check_en = 1'b1;

    do_op("mul_7_m3",   3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1, 0, t);
    do_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 1, 0, t);
    do_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1, 0, t);
    do_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 1, 0, t);
    do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35, 1, 0, t);
    do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35, 1, 0, t);
    do_op("remu_100_7", 3'b111, 32'd100,        32'd7,         32'd2,         35, 1, 0, t);
    do_op("div_b0",     3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 2,  1, 0, t);
    do_op("rem_b0",     3'b110, 32'd5,          32'd0,         32'd5,         2,  1, 0, t);
    do_op("divu_b0",    3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 2,  1, 0, t);
    do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  1, 0, t);
    do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  1, 0, t);
    do_op("divu_big",   3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         35, 1, 0, t);
    do_op("remu_big",   3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 1, 0, t);
    do_op("mul_5_1",    3'b000, 32'd5,          32'd1,         32'd5,         LAT_M1, 1, 0, t);
    do_op("mul_5_0",    3'b000, 32'd5,          32'd0,         32'd0,         LAT_M1, 1, 0, t);
    do_op("divu_100_7", 3'b101, 32'd100,        32'd7,         32'd14,        35, 1, 0, t);

    // flush in the middle of a divide
    req_op = 3'b100; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    t = cyc; req_valid = 1'b0;
    while (cyc < t + 9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_resp_data", resp_data, 32'd14);
    do_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, LAT_M4, 1, 0, t);

    // flush while in DONE suppresses the response
    req_op = 3'b100; req_a = 32'd9; req_b = 32'd0; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_done_valid", {31'd0, resp_valid}, 32'd0);
    chk("flush_done_data", resp_data, 32'd12);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_done_busy", {31'd0, busy}, 32'd0);
    chk("flush_done_data2", resp_data, 32'd12);

    // flush while idle blocks acceptance
    req_op = 3'b000; req_a = 32'd2; req_b = 32'd2; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of an operation
    req_op = 3'b000; req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_data", resp_data, 32'd0);

    // back-to-back: request held high through DONE
    do_op("b2b_first",  3'b000, 32'd7,   32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1, 1, t1);
    do_op("b2b_second", 3'b101, 32'd100, 32'd7,         32'd14,        35, 1, 0, t2);
    chk("b2b_gap", t2 - t1, 32'd36);

    // model-checked mixed operations
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      if (i == 4) rb = 32'd0;
      do_op("mixed", rop, ra, rb, ref_result(rop, ra, rb), ref_lat(rop, ra, rb), 0, 0, t);
    end

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
